// File: rtl/wb_master_pkg.sv
// Shared types and defaults for the Wishbone classic command sequencer.
package wb_master_pkg;

  localparam int unsigned ADR_W_DEF = 32;
  localparam int unsigned DAT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RSP
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [ADR_W_DEF-1:0] adr;
    logic [DAT_W_DEF-1:0] dat;
  } cmd_t;

  // Saturating 8-bit increment used for the timeout event counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous FIFO of command records with full/empty flags; DEPTH must be a power of 2.
module wb_cmd_fifo
  import wb_master_pkg::*;
#(
  parameter type         T     = cmd_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  T            mem_q [DEPTH];
  T            mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/wb_master_seq.sv
// Wishbone classic initiator: queued commands become single-beat cycles, each
// returning one response (read data or timeout error).
module wb_master_seq
  import wb_master_pkg::*;
#(
  parameter int unsigned ADR_W       = ADR_W_DEF,
  parameter int unsigned DAT_W       = DAT_W_DEF,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             busy,
  output logic [7:0]       timeout_cnt,
  output logic             wb_CYC,
  output logic             wb_STB,
  output logic             wb_WE,
  output logic             wb_SEL,
  output logic [ADR_W-1:0] wb_ADR,
  output logic [DAT_W-1:0] wb_DAT_MOSI,
  input  logic [DAT_W-1:0] wb_DAT_MISO,
  input  logic             wb_ACK
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wb_cmd_t;

  wb_cmd_t    push_cmd, head_cmd;
  logic       fifo_full, fifo_empty, fifo_pop;

  state_e     state_q, state_d;
  logic       cyc_q, cyc_d;
  logic       we_q, we_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] tcnt_q, tcnt_d;

  assign push_cmd = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat};

  wb_cmd_fifo #(
    .T    (wb_cmd_t),
    .DEPTH(CMD_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_ni(wb_rst_ni),
    .push  (cmd_valid),
    .din   (push_cmd),
    .pop   (fifo_pop),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready   = !fifo_full;
  assign busy        = !fifo_empty || (state_q != IDLE);
  assign timeout_cnt = tcnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_dat     = rsp_dat_q;
  assign rsp_err     = rsp_err_q;
  assign wb_CYC      = cyc_q;
  assign wb_STB      = cyc_q;
  assign wb_SEL      = cyc_q;
  assign wb_WE       = we_q;
  assign wb_ADR      = adr_q;
  assign wb_DAT_MOSI = dat_q;

  // Next-state, bus and response logic.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    tmo_d       = tmo_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    tcnt_d      = tcnt_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cyc_d    = 1'b1;
          we_d     = head_cmd.we;
          adr_d    = head_cmd.adr;
          dat_d    = head_cmd.dat;
          tmo_d    = '0;
          state_d  = BUS;
        end
      end
      BUS: begin
        // ACK wins over the timeout limit when both land on the same edge.
        if (wb_ACK) begin
          rsp_dat_d   = we_q ? '0 : wb_DAT_MISO;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          state_d     = RSP;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          tcnt_d      = sat_inc8(tcnt_q);
          state_d     = RSP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      tcnt_q      <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed bench for wb_master_seq: table of single transactions plus hand
// sequences for FIFO fill, response back-pressure and mid-cycle reset.
module tb_wb_master_seq;

  logic        clk = 1'b0;
  logic        wb_rst_ni;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic [7:0]  timeout_cnt;
  logic        wb_CYC, wb_STB, wb_WE, wb_SEL, wb_ACK;
  logic [31:0] wb_ADR, wb_DAT_MOSI, wb_DAT_MISO;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  wb_master_seq #(
    .ADR_W      (32),
    .DAT_W      (32),
    .CMD_DEPTH  (4),
    .TIMEOUT_CYC(255)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (wb_rst_ni),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .timeout_cnt(timeout_cnt),
    .wb_CYC     (wb_CYC),
    .wb_STB     (wb_STB),
    .wb_WE      (wb_WE),
    .wb_SEL     (wb_SEL),
    .wb_ADR     (wb_ADR),
    .wb_DAT_MOSI(wb_DAT_MOSI),
    .wb_DAT_MISO(wb_DAT_MISO),
    .wb_ACK     (wb_ACK)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int unsigned ack_wait;   // CYC cycles before ACK; >= 255 means never
    logic [31:0] miso;
    int unsigned exp_cyc;
    logic [31:0] exp_rsp;
    logic        exp_err;
    logic [7:0]  exp_tcnt;
  } vec_t;

  vec_t vecs[5];
  vec_t fill[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    logic rdy;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    for (int t = 0; t < 50; t++) begin
      rdy = cmd_ready;
      @(negedge clk);
      if (rdy) break;
    end
    cmd_valid = 1'b0;
  endtask

  // Acts as the slave for one bus cycle, starting at a negedge.
  task automatic run_bus(input string name, input vec_t v);
    bit          seen = 0;
    bit          stable = 1;
    int unsigned cyc = 0;
    for (int n = 0; n < 20; n++) begin
      if (wb_CYC) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_cyc_start"}, 32'(seen), 32'd1);
    if (!seen) return;
    wb_DAT_MISO = v.miso;
    while (wb_CYC && cyc < 400) begin
      cyc++;
      if (wb_ADR !== v.adr || wb_WE !== v.we || wb_DAT_MOSI !== v.dat ||
          wb_STB !== 1'b1 || wb_SEL !== 1'b1) stable = 0;
      if (cyc > v.ack_wait) wb_ACK = 1'b1;
      @(negedge clk);
      wb_ACK = 1'b0;
    end
    check({name, "_cyc_len"}, cyc, v.exp_cyc);
    check({name, "_bus_stable"}, 32'(stable), 32'd1);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_rsp_dat"}, rsp_dat, v.exp_rsp);
    check({name, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    check({name, "_tcnt"}, 32'(timeout_cnt), 32'(v.exp_tcnt));
    check({name, "_we_after"}, 32'(wb_WE), v.exp_err ? 32'(v.we) : 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0,    32'hFFFFFFFF, 1,   32'h0,        1'b0, 8'd0};
    vecs[1] = '{1'b0, 32'h14, 32'h0,        3,    32'h12345678, 4,   32'h12345678, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 32'h20, 32'h0,        1000, 32'hCAFEF00D, 255, 32'h0,        1'b1, 8'd1};
    vecs[3] = '{1'b0, 32'h28, 32'h0,        254,  32'hA5A50001, 255, 32'hA5A50001, 1'b0, 8'd1};
    vecs[4] = '{1'b1, 32'h2C, 32'h0BADF00D, 1,    32'h77777777, 2,   32'h0,        1'b0, 8'd1};
    for (int i = 0; i < 5; i++) begin
      fill[i] = '{(i == 2), 32'h100 + 32'(i), 32'hD000_0000 + 32'(i), 0,
                  32'h5000_0000 + 32'(i), 1, (i == 2) ? 32'h0 : 32'h5000_0000 + 32'(i),
                  1'b0, 8'd1};
    end

    wb_rst_ni = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b1; wb_ACK = 1'b0; wb_DAT_MISO = '0;
    repeat (3) @(negedge clk);
    check("rst_cyc", 32'(wb_CYC), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_tcnt", 32'(timeout_cnt), 32'd0);
    check("rst_adr", wb_ADR, 32'd0);
    wb_rst_ni = 1'b1;
    @(negedge clk);

    // Single transactions from the table.
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].we, vecs[i].adr, vecs[i].dat);
      run_bus($sformatf("vec%0d", i), vecs[i]);
      repeat (2) @(negedge clk);
    end
    check("idle_busy", 32'(busy), 32'd0);

    // Five commands with cmd_valid held: FIFO fills while the first waits for ACK.
    begin
      int unsigned pushed = 0;
      logic rdy;
      cmd_valid = 1'b1;
      for (int t = 0; t < 40 && pushed < 5; t++) begin
        cmd_we  = fill[pushed].we;
        cmd_adr = fill[pushed].adr;
        cmd_dat = fill[pushed].dat;
        rdy = cmd_ready;
        @(negedge clk);
        if (rdy) pushed++;
      end
      cmd_valid = 1'b0;
      check("fill_pushed", pushed, 32'd5);
      check("fill_ready_low", 32'(cmd_ready), 32'd0);
      check("fill_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) run_bus($sformatf("fill%0d", i), fill[i]);
      repeat (2) @(negedge clk);
    end

    // Response back-pressure: second command must wait for the first response.
    begin
      vec_t a, b;
      bit held = 1;
      a = '{1'b0, 32'h200, 32'h0, 0, 32'h13572468, 1, 32'h13572468, 1'b0, 8'd1};
      b = '{1'b1, 32'h204, 32'h24681357, 0, 32'h0, 1, 32'h0, 1'b0, 8'd1};
      push(a.we, a.adr, a.dat);
      push(b.we, b.adr, b.dat);
      rsp_ready = 1'b0;
      run_bus("bp_first", a);
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_dat !== a.exp_rsp || rsp_err || wb_CYC) held = 0;
      end
      check("bp_hold", 32'(held), 32'd1);
      rsp_ready = 1'b1;
      run_bus("bp_second", b);
      repeat (2) @(negedge clk);
    end

    // Reset while a cycle is in flight with two commands queued.
    begin
      bit quiet = 1;
      push(1'b1, 32'h300, 32'h1);
      push(1'b1, 32'h304, 32'h2);
      push(1'b1, 32'h308, 32'h3);
      check("mid_cyc_active", 32'(wb_CYC), 32'd1);
      wb_rst_ni = 1'b0;
      @(negedge clk);
      check("mid_rst_cyc", 32'(wb_CYC), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_tcnt", 32'(timeout_cnt), 32'd0);
      wb_rst_ni = 1'b1;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (wb_CYC || rsp_valid || busy) quiet = 0;
      end
      check("mid_rst_quiet", 32'(quiet), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
